// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

    localparam int NREQ_MAX = 8;
    localparam int GID_W    = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-write bundle between the producers, the arbiter and the FIFO write port.
interface fifo_wr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    import fifo_arb_pkg::*;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               fifo_full;
    logic               fifo_wr;
    logic [DW-1:0]      fifo_din;
    logic               grant_valid;
    logic [GID_W-1:0]   grant_id;

    // master: producers plus FIFO status; slave: the arbiter itself
    modport master (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr, fifo_din, grant_valid, grant_id
    );

    modport slave (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr, fifo_din, grant_valid, grant_id
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotated-priority first-one picker: searches last+1, last+2, ... modulo NREQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  req,
    input  logic [GID_W-1:0] last,
    output logic             any,
    output logic [GID_W-1:0] idx
);

    localparam logic [GID_W:0] NREQ_L = (GID_W+1)'(NREQ);

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [GID_W:0]    w_base;
    logic [GID_W:0]    w_off;
    logic [GID_W:0]    w_sum;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_base = {1'b0, last} + (GID_W+1)'(1);
        if (w_base >= NREQ_L) begin
            w_base = w_base - NREQ_L;
        end
        // Doubling the vector turns the modulo rotation into a plain shift.
        w_dbl = {req, req};
        w_rot = NREQ'(w_dbl >> w_base);

        any   = 1'b0;
        w_off = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                any   = 1'b1;
                w_off = (GID_W+1)'(j);
            end
        end

        w_sum = w_base + w_off;
        if (w_sum >= NREQ_L) begin
            w_sum = w_sum - NREQ_L;
        end
        idx = w_sum[GID_W-1:0];
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one producer at a time for bursts of up to
// MAX_BURST beats into a shared byte FIFO, stalling while the FIFO is full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    fifo_wr_arbiter_if.slave bus
);

    localparam logic [3:0]       MAX_B    = 4'(MAX_BURST);
    localparam logic [GID_W-1:0] LAST_RST = GID_W'(NREQ - 1);

    state_t           r_state;
    logic             r_grant_valid;
    logic [GID_W-1:0] r_grant_id;
    logic [GID_W-1:0] r_last;
    logic [3:0]       r_burst_cnt;

    logic             w_any;
    logic [GID_W-1:0] w_pick;
    logic             w_sel_valid;
    logic [DW-1:0]    w_sel_data;
    logic             w_active;
    logic             w_beat;
    logic             w_last_beat;
    logic [NREQ-1:0]  w_ready;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req  (bus.req_valid),
        .last (r_last),
        .any  (w_any),
        .idx  (w_pick)
    );

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_ready     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant_id == GID_W'(i)) begin
                w_sel_valid = bus.req_valid[i];
                w_sel_data  = bus.req_data[i*DW +: DW];
            end
        end
        // Outputs are gated by rst so the reset cycle never moves a beat.
        w_active    = rst && (r_state == GRANT);
        w_beat      = w_active && w_sel_valid && !bus.fifo_full;
        w_last_beat = w_beat && ((r_burst_cnt + 4'd1) == MAX_B);
        for (int i = 0; i < NREQ; i++) begin
            w_ready[i] = w_active && !bus.fifo_full && (r_grant_id == GID_W'(i));
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.fifo_wr     = w_beat;
    assign bus.fifo_din    = w_beat ? w_sel_data : '0;
    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_id    = r_grant_id;

    // NOTE: state is updated with non-blocking assignments only; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_burst_cnt   <= '0;
            r_last        <= LAST_RST;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state       <= GRANT;
                        r_grant_valid <= 1'b1;
                        r_grant_id    <= w_pick;
                        r_burst_cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (w_beat && (r_burst_cnt != MAX_B)) begin
                        r_burst_cnt <= r_burst_cnt + 4'd1;
                    end
                    // A dropped valid releases even while the FIFO is full.
                    if (!w_sel_valid || w_last_beat) begin
                        r_state       <= IDLE;
                        r_grant_valid <= 1'b0;
                        r_last        <= r_grant_id;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
